// File: rtl/g2b_rr_arbiter.sv
// g2b_rr_arbiter: round-robin arbiter that shares one registered Gray-to-binary
// converter among N_REQ requesters and returns the result tagged with the
// requester index on a single valid/ready channel.
// Optional feature: define G2B_STEP_CHK_EN to flag results that are neither
// equal to nor one above the previous result from the same requester.
module g2b_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4,
    parameter int ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_gray,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_bin,
    output logic [ID_W-1:0]        out_id,
    output logic                   out_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   id_q;
    logic [WIDTH-1:0]  gray_q;

    logic [N_REQ-1:0]  req_rot;
    logic [ID_W:0]     idx_sum;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   next_ptr;
    logic              found;
    logic [WIDTH-1:0]  gray_sel;
    logic [WIDTH-1:0]  conv_bin;
    logic              err_next;

    // Rotate the request vector so bit 0 is the requester at ptr, then take the first set bit
    always_comb begin
        req_rot = N_REQ'({req_valid, req_valid} >> ptr);
        found   = 1'b0;
        winner  = '0;
        idx_sum = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req_rot[k]) begin
                found   = 1'b1;
                idx_sum = {1'b0, ptr} + (ID_W+1)'(k);
                if (idx_sum >= (ID_W+1)'(N_REQ)) begin
                    idx_sum = idx_sum - (ID_W+1)'(N_REQ);
                end
                winner = idx_sum[ID_W-1:0];
            end
        end
    end

    // Pointer advances to the requester just after the winner, wrapping at N_REQ
    always_comb begin
        next_ptr = winner + ID_W'(1);
        if (winner == ID_W'(N_REQ - 1)) begin
            next_ptr = '0;
        end
    end

    // Select the winner's Gray word from the flattened request bus
    always_comb begin
        gray_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                gray_sel = req_gray[i*WIDTH +: WIDTH];
            end
        end
    end

    // Grant is one-hot to the winner, only while idle and never while reset is asserted
    always_comb begin
        req_ready = '0;
        if (!rst && state == IDLE && found) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Binary bit i is the XOR of all Gray bits from the MSB down to bit i
    always_comb begin
        conv_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            conv_bin[i] = ^(gray_q >> i);
        end
    end

`ifdef G2B_STEP_CHK_EN
    logic [WIDTH-1:0] last_bin [N_REQ];
    logic [N_REQ-1:0] seen;
    logic [WIDTH-1:0] last_inc;

    // A step is legal if the value repeats or advances by exactly one (mod 2^WIDTH)
    always_comb begin
        last_inc = last_bin[id_q] + WIDTH'(1);
        err_next = seen[id_q] && (conv_bin != last_bin[id_q]) && (conv_bin != last_inc);
    end

    // Remember the last converted value of each requester once it has produced one
    always_ff @(posedge clk) begin
        if (rst) begin
            seen <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                last_bin[i] <= '0;
            end
        end else if (state == CONV) begin
            last_bin[id_q] <= conv_bin;
            seen[id_q]     <= 1'b1;
        end
    end
`else
    assign err_next = 1'b0;
`endif

    // Main FSM: grant in IDLE, convert in CONV, hold the result in OUT until accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gray_q    <= '0;
            id_q      <= '0;
            out_valid <= 1'b0;
            out_bin   <= '0;
            out_id    <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        gray_q <= gray_sel;
                        id_q   <= winner;
                        ptr    <= next_ptr;
                        state  <= CONV;
                    end
                end
                CONV: begin
                    out_bin   <= conv_bin;
                    out_id    <= id_q;
                    out_err   <= err_next;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
